lt24_region_scheduler: RTL

//  Arbitrates the LT24Display pixel interface between two rectangle-draw requesters: req 0 = clock banner renderer, req 1 = board renderer.

---
 rtl/lt24_region_scheduler_if.sv | 37 +++
 rtl/lt24_region_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lt24_region_scheduler_if.sv
// Pixel-bus and rectangle-request bundle between the region scheduler,
// its two requesters and the LT24 display driver.
// Per-requester fields are packed {req1, req0}.
interface lt24_region_scheduler_if;
  logic [1:0]  reqValid;
  logic [15:0] reqX0;
  logic [15:0] reqX1;
  logic [17:0] reqY0;
  logic [17:0] reqY1;
  logic [31:0] srcData;
  logic [1:0]  reqAck;
  logic [1:0]  reqDone;
  logic [1:0]  reqError;
  logic        grant;
  logic        busy;
  logic [7:0]  scanX;
  logic [8:0]  scanY;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;

  // Scheduler side: drives the pixel bus and the per-requester status pulses.
  modport master (
    input  reqValid, reqX0, reqX1, reqY0, reqY1, srcData, pixelReady,
    output reqAck, reqDone, reqError, grant, busy, scanX, scanY,
           xAddr, yAddr, pixelData, pixelWrite
  );

  // Requesters / display side.
  modport slave (
    output reqValid, reqX0, reqX1, reqY0, reqY1, srcData, pixelReady,
    input  reqAck, reqDone, reqError, grant, busy, scanX, scanY,
           xAddr, yAddr, pixelData, pixelWrite
  );
endinterface

// File: rtl/lt24_region_scheduler.sv
// Round-robin arbiter between two rectangle requesters for the LT24 pixel
// interface. The granted rectangle is raster-scanned one pixel per accepted
// pixelWrite/pixelReady handshake; malformed rectangles are rejected without
// writing any pixel.
module lt24_region_scheduler #(
  parameter int LCD_WIDTH  = 240,
  parameter int LCD_HEIGHT = 320
) (
  input logic                   clock,
  input logic                   reset,
  lt24_region_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE, REJECT} state_t;

  // Limits widened by one bit so x1=255 / y1=511 compare correctly.
  localparam logic [8:0] X_LIMIT = 9'(LCD_WIDTH);
  localparam logic [9:0] Y_LIMIT = 10'(LCD_HEIGHT);

  state_t     state_reg, state_next;
  logic       grant_reg;
  logic       last_grant_reg;
  logic       ack_reg;
  logic [7:0] x0_reg, x1_reg, scan_x_reg;
  logic [8:0] y0_reg, y1_reg, scan_y_reg;

  // Per-requester views of the packed request buses.
  logic [7:0]  req_x0 [2];
  logic [7:0]  req_x1 [2];
  logic [8:0]  req_y0 [2];
  logic [8:0]  req_y1 [2];
  logic [15:0] req_data [2];
  logic [1:0]  grant_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_x0[gi]   = bus.reqX0[gi*8 +: 8];
      assign req_x1[gi]   = bus.reqX1[gi*8 +: 8];
      assign req_y0[gi]   = bus.reqY0[gi*9 +: 9];
      assign req_y1[gi]   = bus.reqY1[gi*9 +: 9];
      assign req_data[gi] = bus.srcData[gi*16 +: 16];
      assign grant_onehot[gi] = (grant_reg == 1'(gi));
    end
  endgenerate

  // Arbitration: a lone request wins; on a tie the one not served last wins.
  logic       pick;
  logic [7:0] sel_x0, sel_x1;
  logic [8:0] sel_y0, sel_y1;
  logic       bad_rect;
  logic       last_x, last_y;

  assign pick   = (bus.reqValid == 2'b11) ? ~last_grant_reg : bus.reqValid[1];
  assign sel_x0 = req_x0[pick];
  assign sel_x1 = req_x1[pick];
  assign sel_y0 = req_y0[pick];
  assign sel_y1 = req_y1[pick];

  assign bad_rect = (sel_x0 > sel_x1) || (sel_y0 > sel_y1) ||
                    ({1'b0, sel_x1} >= X_LIMIT) || ({1'b0, sel_y1} >= Y_LIMIT);

  assign last_x = (scan_x_reg == x1_reg);
  assign last_y = (scan_y_reg == y1_reg);

  // State register; reset aborts any scan in progress without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_next     = state_reg;
    bus.pixelWrite = 1'b0;
    bus.pixelData  = 16'h0000;
    bus.reqDone    = 2'b00;
    bus.reqError   = 2'b00;
    case (state_reg)
      IDLE: begin
        if (bus.reqValid != 2'b00) begin
          state_next = bad_rect ? REJECT : SCAN;
        end
      end
      SCAN: begin
        bus.pixelWrite = 1'b1;
        bus.pixelData  = req_data[grant_reg];
        if (bus.pixelReady && last_x && last_y) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.reqDone = grant_onehot;
        state_next  = IDLE;
      end
      REJECT: begin
        bus.reqDone  = grant_onehot;
        bus.reqError = grant_onehot;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant bookkeeping, bound latching and raster-scan coordinate stepping.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      ack_reg        <= 1'b0;
      x0_reg         <= '0;
      x1_reg         <= '0;
      y0_reg         <= '0;
      y1_reg         <= '0;
      scan_x_reg     <= '0;
      scan_y_reg     <= '0;
    end else begin
      ack_reg <= 1'b0;
      if (state_reg == IDLE && bus.reqValid != 2'b00) begin
        grant_reg      <= pick;
        last_grant_reg <= pick;
        ack_reg        <= 1'b1;
        x0_reg         <= sel_x0;
        x1_reg         <= sel_x1;
        y0_reg         <= sel_y0;
        y1_reg         <= sel_y1;
        scan_x_reg     <= sel_x0;
        scan_y_reg     <= sel_y0;
      end else if (state_reg == SCAN && bus.pixelReady) begin
        if (!last_x) begin
          scan_x_reg <= scan_x_reg + 8'd1;
        end else if (!last_y) begin
          scan_x_reg <= x0_reg;
          scan_y_reg <= scan_y_reg + 9'd1;
        end
      end
    end
  end

  // Pass-through and status outputs.
  always_comb begin
    bus.reqAck = ack_reg ? grant_onehot : 2'b00;
    bus.grant  = grant_reg;
    bus.busy   = (state_reg != IDLE);
    bus.scanX  = scan_x_reg;
    bus.scanY  = scan_y_reg;
    bus.xAddr  = scan_x_reg;
    bus.yAddr  = scan_y_reg;
  end

endmodule
